// File: rtl/rom_arb_pkg.sv
// Shared encodings for the ROM access arbiter: FSM states and the current port owner.
package rom_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_BUSY = 2'd2,
    ST_DONE = 2'd3
  } arb_state_t;

  typedef enum logic [1:0] {
    OWN_NONE  = 2'd0,
    OWN_LD    = 2'd1,
    OWN_FETCH = 2'd2
  } owner_t;

endpackage

// File: rtl/rom_access_arbiter.sv
// Shares the external ROM/SRAM controller port between the program loader (writes) and the
// CPU fetch path (reads), one latched transaction at a time over the request/busy handshake.
module rom_access_arbiter
  import rom_arb_pkg::*;
#(
  parameter int DATA_WIDTH    = 16,
  parameter int ADDRESS_WIDTH = 16,
  parameter int TIMEOUT       = 255
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     load_active,
  input  logic                     ld_request,
  input  logic [ADDRESS_WIDTH-1:0] ld_address,
  input  logic [DATA_WIDTH-1:0]    ld_data,
  output logic                     ld_busy,
  output logic                     ld_initialized,
  input  logic                     fetch_request,
  input  logic [ADDRESS_WIDTH-1:0] fetch_address,
  output logic                     fetch_busy,
  output logic                     fetch_valid,
  output logic [DATA_WIDTH-1:0]    fetch_data,
  output logic                     cpu_hold,
  output logic                     mem_request,
  output logic                     mem_write,
  output logic [ADDRESS_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0]    mem_wdata,
  input  logic [DATA_WIDTH-1:0]    mem_rdata,
  input  logic                     mem_busy,
  input  logic                     mem_initialized,
  output logic                     timeout_err
);

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_LIMIT = CW'(TIMEOUT);

  arb_state_t               state_q, state_d;
  owner_t                   owner_q, owner_d;
  logic [CW-1:0]            count_q, count_d, count_inc;
  logic                     mem_request_d, mem_write_d, timeout_err_d;
  logic [ADDRESS_WIDTH-1:0] mem_address_d;
  logic [DATA_WIDTH-1:0]    mem_wdata_d, fetch_data_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= ST_IDLE;
      owner_q        <= OWN_NONE;
      count_q        <= '0;
      mem_request    <= 1'b0;
      mem_write      <= 1'b0;
      mem_address    <= '0;
      mem_wdata      <= '0;
      fetch_data     <= '0;
      timeout_err    <= 1'b0;
      ld_initialized <= 1'b0;
      cpu_hold       <= 1'b0;
    end else begin
      state_q        <= state_d;
      owner_q        <= owner_d;
      count_q        <= count_d;
      mem_request    <= mem_request_d;
      mem_write      <= mem_write_d;
      mem_address    <= mem_address_d;
      mem_wdata      <= mem_wdata_d;
      fetch_data     <= fetch_data_d;
      timeout_err    <= timeout_err_d;
      ld_initialized <= mem_initialized;
      cpu_hold       <= load_active | ~mem_initialized | (owner_q == OWN_LD);
    end
  end

  // The counter saturates at the limit so a disabled timeout (TIMEOUT=0) never wraps.
  assign count_inc = (count_q == CNT_LIMIT) ? count_q : count_q + CW'(1);

  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    count_d       = count_q;
    mem_request_d = mem_request;
    mem_write_d   = mem_write;
    mem_address_d = mem_address;
    mem_wdata_d   = mem_wdata;
    fetch_data_d  = fetch_data;
    timeout_err_d = timeout_err;

    case (state_q)
      ST_IDLE: begin
        if (mem_initialized) begin
          if (ld_request && load_active) begin
            owner_d       = OWN_LD;
            mem_write_d   = 1'b1;
            mem_address_d = ld_address;
            mem_wdata_d   = ld_data;
            mem_request_d = 1'b1;
            count_d       = '0;
            state_d       = ST_REQ;
          end else if (fetch_request && !load_active) begin
            owner_d       = OWN_FETCH;
            mem_write_d   = 1'b0;
            mem_address_d = fetch_address;
            mem_request_d = 1'b1;
            count_d       = '0;
            state_d       = ST_REQ;
          end
        end
      end

      ST_REQ: begin
        if (mem_busy) begin
          mem_request_d = 1'b0;
          state_d       = ST_BUSY;
        end else begin
          count_d = count_inc;
          // Abandon without acking the requester; a held fetch simply retries from IDLE.
          if ((TIMEOUT != 0) && (count_inc == CNT_LIMIT)) begin
            mem_request_d = 1'b0;
            timeout_err_d = 1'b1;
            owner_d       = OWN_NONE;
            state_d       = ST_IDLE;
          end
        end
      end

      ST_BUSY: begin
        if (!mem_busy) begin
          if (owner_q == OWN_FETCH) begin
            fetch_data_d = mem_rdata;
          end
          state_d = ST_DONE;
        end
      end

      ST_DONE: begin
        owner_d = OWN_NONE;
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // A fetch in flight also blocks the loader, and a loader transaction also blocks the CPU.
  assign ld_busy     = ((state_q != ST_IDLE) && (owner_q == OWN_LD)) || (owner_q == OWN_FETCH);
  assign fetch_busy  = ((owner_q == OWN_FETCH) && (state_q != ST_IDLE)) || (owner_q == OWN_LD);
  assign fetch_valid = (state_q == ST_DONE) && (owner_q == OWN_FETCH);

endmodule

// File: tb/tb_rom_access_arbiter.sv
// Self-checking bench for rom_access_arbiter: a behavioural controller responder, a table of
// directed transactions, hand-written corner sequences and randomized traffic against a model.
module tb_rom_access_arbiter;

  localparam int DW      = 16;
  localparam int AW      = 16;
  localparam int TMO     = 4;
  localparam int W_NONE  = 0;
  localparam int W_LD    = 1;
  localparam int W_FETCH = 2;

  typedef struct {
    bit          ld_req;
    bit          f_req;
    bit          la;
    logic [15:0] addr;
    logic [15:0] data;
    int          busy;
    int          exp_winner;
    logic [15:0] exp_rdata;
  } vec_t;

  logic          clk;
  logic          reset_n;
  logic          load_active;
  logic          ld_request;
  logic [AW-1:0] ld_address;
  logic [DW-1:0] ld_data;
  logic          ld_busy;
  logic          ld_initialized;
  logic          fetch_request;
  logic [AW-1:0] fetch_address;
  logic          fetch_busy;
  logic          fetch_valid;
  logic [DW-1:0] fetch_data;
  logic          cpu_hold;
  logic          mem_request;
  logic          mem_write;
  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_busy;
  logic          mem_initialized;
  logic          timeout_err;

  int          checks = 0;
  int          failures = 0;
  int          ctrl_latency = 1;
  int          ctrl_busy_cycles = 1;
  bit          ctrl_enable = 1'b1;
  logic [15:0] ctrl_mem [logic [15:0]];
  logic [15:0] shadow [logic [15:0]];
  logic [15:0] last_rdata = '0;

  rom_access_arbiter #(
    .DATA_WIDTH   (DW),
    .ADDRESS_WIDTH(AW),
    .TIMEOUT      (TMO)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .load_active    (load_active),
    .ld_request     (ld_request),
    .ld_address     (ld_address),
    .ld_data        (ld_data),
    .ld_busy        (ld_busy),
    .ld_initialized (ld_initialized),
    .fetch_request  (fetch_request),
    .fetch_address  (fetch_address),
    .fetch_busy     (fetch_busy),
    .fetch_valid    (fetch_valid),
    .fetch_data     (fetch_data),
    .cpu_hold       (cpu_hold),
    .mem_request    (mem_request),
    .mem_write      (mem_write),
    .mem_address    (mem_address),
    .mem_wdata      (mem_wdata),
    .mem_rdata      (mem_rdata),
    .mem_busy       (mem_busy),
    .mem_initialized(mem_initialized),
    .timeout_err    (timeout_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Unwritten ROM locations read back as a fixed function of their address.
  function automatic logic [15:0] rom_default(input logic [15:0] a);
    return a ^ 16'h5A5A;
  endfunction

  function automatic logic [15:0] model_read(input logic [15:0] a);
    return shadow.exists(a) ? shadow[a] : rom_default(a);
  endfunction

  function automatic int model_winner(input bit ld, input bit f, input bit la);
    if (ld && la) return W_LD;
    if (f && !la) return W_FETCH;
    return W_NONE;
  endfunction

  // Controller model: accepts a request after ctrl_latency cycles, stays busy ctrl_busy_cycles.
  initial begin : responder
    logic [15:0] a;
    logic [15:0] d;
    logic        w;
    mem_busy  = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk);
      #2;
      if (ctrl_enable && reset_n && mem_request && !mem_busy) begin
        a = mem_address;
        d = mem_wdata;
        w = mem_write;
        repeat (ctrl_latency) begin @(posedge clk); #2; end
        mem_busy = 1'b1;
        repeat (ctrl_busy_cycles) begin @(posedge clk); #2; end
        if (w) begin
          ctrl_mem[a] = d;
          mem_rdata   = 16'($urandom);
        end else begin
          mem_rdata = ctrl_mem.exists(a) ? ctrl_mem[a] : rom_default(a);
        end
        mem_busy = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  task automatic quiesce();
    int i;
    i = 0;
    while (i < 40 && (mem_busy || ld_busy || fetch_busy || mem_request)) begin
      tick();
      i++;
    end
    if (i == 40) checkOutput("quiesce_timeout", 64'(1), 64'(0));
  endtask

  task automatic applyStimulus(input bit ld_req, input bit f_req, input bit la,
                               input logic [15:0] addr, input logic [15:0] data,
                               input int busy_cycles, input int exp_winner,
                               input logic [15:0] exp_rdata, input bit drop_init);
    int          cyc;
    bit          granted;
    bit          done;
    int          pulses;
    logic [15:0] cap;
    int          busy_low_at;
    int          ldb_low_at;
    bit          saw_mb;
    granted = 1'b0; done = 1'b0; pulses = 0; cap = '0;
    busy_low_at = -1; ldb_low_at = -1; saw_mb = 1'b0;
    ctrl_busy_cycles = busy_cycles;
    load_active   = la;
    ld_request    = ld_req;
    fetch_request = f_req;
    ld_address    = (exp_winner == W_FETCH) ? ~addr : addr;
    fetch_address = (exp_winner == W_LD) ? ~addr : addr;
    ld_data       = data;
    for (int i = 0; i < 6 && !granted; i++) begin
      tick();
      granted = mem_request;
    end
    if (exp_winner == W_NONE) begin
      checkOutput("no_grant", 64'(granted), 64'(0));
      ld_request = 1'b0;
      fetch_request = 1'b0;
      quiesce();
      return;
    end
    checkOutput("grant", 64'(granted), 64'(1));
    ld_request = 1'b0;
    fetch_request = 1'b0;
    if (!granted) begin
      quiesce();
      return;
    end
    checkOutput("mem_write", 64'(mem_write), 64'(exp_winner == W_LD));
    checkOutput("mem_address", 64'(mem_address), 64'(addr));
    if (exp_winner == W_LD) checkOutput("mem_wdata", 64'(mem_wdata), 64'(data));
    cyc = 0;
    while (!done && cyc < 40) begin
      if (mem_busy) begin
        saw_mb = 1'b1;
        if (drop_init) mem_initialized = 1'b0;
      end else if (saw_mb && busy_low_at < 0) begin
        busy_low_at = cyc;
      end
      if (fetch_valid) begin
        pulses++;
        cap = fetch_data;
      end
      if (exp_winner == W_LD && !ld_busy) begin
        ldb_low_at = cyc;
        done = 1'b1;
      end
      if (exp_winner == W_FETCH && !fetch_busy) done = 1'b1;
      if (!done) begin
        tick();
        cyc++;
      end
    end
    checkOutput("txn_complete", 64'(done), 64'(1));
    if (exp_winner == W_LD) begin
      checkOutput("ld_busy_fall_delay", 64'(ldb_low_at - busy_low_at), 64'(1));
      checkOutput("fetch_data_hold", 64'(fetch_data), 64'(last_rdata));
    end else begin
      tick();
      if (fetch_valid) pulses++;
      checkOutput("fetch_valid_pulses", 64'(pulses), 64'(1));
      checkOutput("fetch_data", 64'(cap), 64'(exp_rdata));
      last_rdata = exp_rdata;
    end
    quiesce();
  endtask

  task automatic waitFetch(input string name, input logic [15:0] exp);
    bit          seen;
    bit          done;
    int          pulses;
    logic [15:0] cap;
    seen = 1'b0; done = 1'b0; pulses = 0; cap = '0;
    for (int i = 0; i < 40 && !done; i++) begin
      tick();
      if (fetch_busy) begin
        seen = 1'b1;
        fetch_request = 1'b0;
      end else if (seen) begin
        done = 1'b1;
      end
      if (fetch_valid) begin
        pulses++;
        cap = fetch_data;
      end
    end
    checkOutput({name, "_done"}, 64'(done), 64'(1));
    checkOutput({name, "_pulses"}, 64'(pulses), 64'(1));
    checkOutput({name, "_data"}, 64'(cap), 64'(exp));
    last_rdata = exp;
  endtask

  initial begin : watchdog
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : main
    vec_t        vecs [11];
    logic [15:0] pool [8];
    bit          granted;
    bit          inbusy;
    int          highs;
    bit          r_ld;
    bit          r_f;
    bit          r_la;
    logic [15:0] r_addr;
    int          win;

    vecs[0]  = '{1'b1, 1'b0, 1'b1, 16'h0005, 16'hBEEF, 3, W_LD,    16'h0000};
    vecs[1]  = '{1'b1, 1'b0, 1'b1, 16'h0010, 16'h1234, 1, W_LD,    16'h0000};
    vecs[2]  = '{1'b0, 1'b1, 1'b0, 16'h0010, 16'h0000, 2, W_FETCH, 16'h1234};
    vecs[3]  = '{1'b0, 1'b1, 1'b0, 16'h0005, 16'h0000, 1, W_FETCH, 16'hBEEF};
    vecs[4]  = '{1'b1, 1'b0, 1'b0, 16'h0020, 16'hAAAA, 1, W_NONE,  16'h0000};
    vecs[5]  = '{1'b0, 1'b1, 1'b1, 16'h0020, 16'h0000, 1, W_NONE,  16'h0000};
    vecs[6]  = '{1'b1, 1'b1, 1'b1, 16'hFFFF, 16'h0000, 1, W_LD,    16'h0000};
    vecs[7]  = '{1'b0, 1'b1, 1'b0, 16'hFFFF, 16'h0000, 4, W_FETCH, 16'h0000};
    vecs[8]  = '{1'b1, 1'b0, 1'b1, 16'h0000, 16'hFFFF, 2, W_LD,    16'h0000};
    vecs[9]  = '{1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000, 1, W_FETCH, 16'hFFFF};
    vecs[10] = '{1'b0, 1'b1, 1'b0, 16'h0020, 16'h0000, 1, W_FETCH, 16'h5A7A};
    pool = '{16'h0005, 16'h0010, 16'h0020, 16'hFFFF, 16'h0000, 16'h1234, 16'h8000, 16'h00FF};

    reset_n = 1'b0; mem_initialized = 1'b0; load_active = 1'b1; ld_request = 1'b1;
    ld_address = '0; ld_data = '0; fetch_request = 1'b0; fetch_address = '0;

    // Reset while the memory is uninitialized and the loader is already asking.
    repeat (2) tick();
    checkOutput("reset_outputs",
                64'({ld_busy, ld_initialized, cpu_hold, mem_request, fetch_valid, fetch_busy, timeout_err}),
                64'(0));
    checkOutput("reset_fetch_data", 64'(fetch_data), 64'(0));
    reset_n = 1'b1;
    repeat (4) tick();
    checkOutput("uninit_no_request", 64'(mem_request), 64'(0));
    checkOutput("uninit_ld_busy", 64'(ld_busy), 64'(0));
    checkOutput("uninit_ld_initialized", 64'(ld_initialized), 64'(0));
    checkOutput("uninit_cpu_hold", 64'(cpu_hold), 64'(1));
    ld_request = 1'b0;
    mem_initialized = 1'b1;
    tick();
    checkOutput("ld_initialized_follows", 64'(ld_initialized), 64'(1));

    for (int i = 0; i < 11; i++) begin
      ctrl_latency = i % 3;
      applyStimulus(vecs[i].ld_req, vecs[i].f_req, vecs[i].la, vecs[i].addr, vecs[i].data,
                    vecs[i].busy, vecs[i].exp_winner, vecs[i].exp_rdata, 1'b0);
      if (vecs[i].exp_winner == W_LD) shadow[vecs[i].addr] = vecs[i].data;
    end

    // Loader wins a simultaneous request; the held fetch waits for load_active to drop.
    ctrl_latency = 1;
    applyStimulus(1'b1, 1'b1, 1'b1, 16'h0040, 16'h4444, 2, W_LD, 16'h0000, 1'b0);
    shadow[16'h0040] = 16'h4444;
    load_active = 1'b1;
    fetch_address = 16'h0040;
    fetch_request = 1'b1;
    granted = 1'b0;
    repeat (5) begin
      tick();
      granted = granted | mem_request;
    end
    checkOutput("fetch_blocked_by_load", 64'(granted), 64'(0));
    checkOutput("cpu_hold_during_load", 64'(cpu_hold), 64'(1));
    load_active = 1'b0;
    waitFetch("fetch_after_load", 16'h4444);
    quiesce();

    // mem_initialized drops mid-write: the write finishes, then new grants are refused.
    applyStimulus(1'b1, 1'b0, 1'b1, 16'h0050, 16'h5555, 3, W_LD, 16'h0000, 1'b1);
    shadow[16'h0050] = 16'h5555;
    applyStimulus(1'b1, 1'b0, 1'b1, 16'h0060, 16'h6666, 1, W_NONE, 16'h0000, 1'b0);
    checkOutput("cpu_hold_uninit_again", 64'(cpu_hold), 64'(1));
    checkOutput("ld_initialized_low", 64'(ld_initialized), 64'(0));
    mem_initialized = 1'b1;
    repeat (2) tick();
    applyStimulus(1'b0, 1'b1, 1'b0, 16'h0050, 16'h0000, 2, W_FETCH, 16'h5555, 1'b0);

    // Controller never answers: the request is dropped after TMO cycles and the fetch retries.
    ctrl_latency = 0;
    ctrl_enable = 1'b0;
    load_active = 1'b0;
    fetch_address = 16'h0005;
    fetch_request = 1'b1;
    tick();
    highs = 0;
    while (mem_request && highs < 20) begin
      highs++;
      tick();
    end
    checkOutput("timeout_request_cycles", 64'(highs), 64'(TMO));
    checkOutput("timeout_err_set", 64'(timeout_err), 64'(1));
    checkOutput("timeout_not_acked", 64'({fetch_busy, fetch_valid}), 64'(0));
    ctrl_enable = 1'b1;
    waitFetch("timeout_retry", model_read(16'h0005));
    checkOutput("timeout_err_sticky", 64'(timeout_err), 64'(1));
    quiesce();
    reset_n = 1'b0;
    #1;
    checkOutput("timeout_err_cleared", 64'(timeout_err), 64'(0));
    tick();
    reset_n = 1'b1;
    last_rdata = '0;
    tick();

    // Asynchronous reset while the controller is busy, then a clean fetch.
    ctrl_busy_cycles = 8;
    fetch_address = 16'h0010;
    fetch_request = 1'b1;
    inbusy = 1'b0;
    for (int i = 0; i < 20 && !inbusy; i++) begin
      tick();
      if (fetch_busy) fetch_request = 1'b0;
      inbusy = mem_busy && !mem_request && fetch_busy;
    end
    checkOutput("reached_busy", 64'(inbusy), 64'(1));
    reset_n = 1'b0;
    #1;
    checkOutput("reset_mid_outputs",
                64'({ld_busy, ld_initialized, fetch_busy, fetch_valid, cpu_hold, mem_request,
                     mem_write, timeout_err, fetch_data, mem_address, mem_wdata}),
                64'(0));
    tick();
    reset_n = 1'b1;
    last_rdata = '0;
    for (int i = 0; i < 20 && mem_busy; i++) tick();
    tick();
    applyStimulus(1'b0, 1'b1, 1'b0, 16'h0010, 16'h0000, 2, W_FETCH, model_read(16'h0010), 1'b0);

    for (int n = 0; n < 40; n++) begin
      r_ld   = 1'($urandom_range(0, 1));
      r_f    = 1'($urandom_range(0, 1));
      r_la   = 1'($urandom_range(0, 1));
      r_addr = pool[$urandom_range(0, 7)];
      ctrl_latency = $urandom_range(0, 2);
      win = model_winner(r_ld, r_f, r_la);
      applyStimulus(r_ld, r_f, r_la, r_addr, 16'($urandom), $urandom_range(1, 4), win,
                    model_read(r_addr), 1'b0);
      if (win == W_LD) shadow[r_addr] = ld_data;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
